rob_retire_queue: RTL

- Circular in-order retirement queue for the R10K-style rename datapath.
- Dispatch pushes {T, T_old, arch reg} per renamed instruction.
- The CDB marks entries complete.
- The head entry retires in order and drives T_old plus a one-cycle enable into the Free_List.
- It is the producer of the Free_List retire inputs (enable/T_old), the counterpart to the Free_List's own allocation side.

---
 rtl/rob_retire_queue_pkg.sv | 30 +++
 rtl/rob_retire_queue.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/rob_retire_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rob_retire_queue_pkg
// Description : Shared defaults and types for the in-order retirement queue
//               of the R10K-style rename datapath (physical/architectural
//               register types and the queue entry layout).
// Revision    : 1.0 - initial release
// ============================================================================
package rob_retire_queue_pkg;

    localparam int DEF_ROB_SIZE     = 8;
    localparam int DEF_NUM_PHYS_REG = 64;
    localparam int DEF_NUM_GEN_REG  = 32;

    localparam int PHYS_REG_W = $clog2(DEF_NUM_PHYS_REG);
    localparam int ARCH_REG_W = $clog2(DEF_NUM_GEN_REG);

    typedef logic [PHYS_REG_W-1:0] phys_reg_t;
    typedef logic [ARCH_REG_W-1:0] arch_reg_t;

    typedef struct packed {
        logic      valid;
        logic      complete;
        phys_reg_t T;
        phys_reg_t T_old;
        arch_reg_t arch;
    } rob_entry_t;

endpackage : rob_retire_queue_pkg
`default_nettype wire

// File: rtl/rob_retire_queue.sv
`default_nettype none
// ============================================================================
// Module      : rob_retire_queue
// Description : Circular in-order retirement queue. Dispatch pushes
//               {T, T_old, arch}; CDB broadcasts mark entries complete; the
//               head retires once complete and hands T_old to the Free_List.
// Ports       : clock/reset        - clock, async active-low reset
//               dispatch_en/T_in/T_old_in/arch_in - push interface
//               cdb_en/cdb_tag     - completion broadcast
//               flush              - mispredict, discards all entries
//               full/empty/num_entries - occupancy status
//               retire_en/retire_T_old/retire_T/retire_arch - commit output
// Revision    : 1.0 - initial release
// ============================================================================
module rob_retire_queue
    import rob_retire_queue_pkg::*;
#(
    parameter int ROB_SIZE     = DEF_ROB_SIZE,
    parameter int NUM_PHYS_REG = DEF_NUM_PHYS_REG,
    parameter int NUM_GEN_REG  = DEF_NUM_GEN_REG
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            dispatch_en,
    input  logic [$clog2(NUM_PHYS_REG)-1:0] T_in,
    input  logic [$clog2(NUM_PHYS_REG)-1:0] T_old_in,
    input  logic [$clog2(NUM_GEN_REG)-1:0]  arch_in,
    input  logic                            cdb_en,
    input  logic [$clog2(NUM_PHYS_REG)-1:0] cdb_tag,
    input  logic                            flush,
    output logic                            full,
    output logic                            empty,
    output logic [$clog2(ROB_SIZE+1)-1:0]   num_entries,
    output logic                            retire_en,
    output logic [$clog2(NUM_PHYS_REG)-1:0] retire_T_old,
    output logic [$clog2(NUM_PHYS_REG)-1:0] retire_T,
    output logic [$clog2(NUM_GEN_REG)-1:0]  retire_arch
);

    localparam int PHYS_W = $clog2(NUM_PHYS_REG);
    localparam int ARCH_W = $clog2(NUM_GEN_REG);
    localparam int PTR_W  = $clog2(ROB_SIZE);
    localparam int CNT_W  = $clog2(ROB_SIZE+1);

    typedef struct packed {
        logic              valid;
        logic              complete;
        logic [PHYS_W-1:0] T;
        logic [PHYS_W-1:0] T_old;
        logic [ARCH_W-1:0] arch;
    } entry_t;

    entry_t             entry_q [ROB_SIZE];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    entry_t             head_entry;
    logic               dispatch_ok;
    logic [ROB_SIZE-1:0] cdb_hit;

    // Status is derived from registered occupancy only, so a retire in the
    // same cycle never unblocks a dispatch while full.
    assign full        = (count_q == CNT_W'(ROB_SIZE));
    assign empty       = (count_q == '0);
    assign num_entries = count_q;

    assign head_entry  = entry_q[head_q];
    assign retire_en   = head_entry.valid & head_entry.complete & ~flush;

    // Outputs are gated to zero so the Free_List never sees stale tags.
    assign retire_T_old = retire_en ? head_entry.T_old : '0;
    assign retire_T     = retire_en ? head_entry.T     : '0;
    assign retire_arch  = retire_en ? head_entry.arch  : '0;

    assign dispatch_ok = dispatch_en & ~full & ~flush;

    // Completion match per entry. The tail slot being written this cycle is
    // invalid, so a same-cycle tag cannot be captured for it.
    for (genvar i = 0; i < ROB_SIZE; i++) begin : g_cdb_match
        assign cdb_hit[i] = cdb_en & entry_q[i].valid & ~entry_q[i].complete
                          & (entry_q[i].T == cdb_tag);
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // Power-of-two depth: pointer wrap is plain overflow.
            if (retire_en)   head_d = head_q + PTR_W'(1);
            if (dispatch_ok) tail_d = tail_q + PTR_W'(1);
            count_d = count_q + CNT_W'(dispatch_ok) - CNT_W'(retire_en);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < ROB_SIZE; i++) begin
                if (flush) begin
                    entry_q[i].valid    <= 1'b0;
                    entry_q[i].complete <= 1'b0;
                end else begin
                    if (cdb_hit[i]) begin
                        entry_q[i].complete <= 1'b1;
                    end
                    if (retire_en && (head_q == PTR_W'(i))) begin
                        entry_q[i].valid    <= 1'b0;
                        entry_q[i].complete <= 1'b0;
                    end
                    // Head and tail only coincide when empty (no retire) or
                    // full (no dispatch), so these writes never collide.
                    if (dispatch_ok && (tail_q == PTR_W'(i))) begin
                        entry_q[i].valid    <= 1'b1;
                        entry_q[i].complete <= 1'b0;
                        entry_q[i].T        <= T_in;
                        entry_q[i].T_old    <= T_old_in;
                        entry_q[i].arch     <= arch_in;
                    end
                end
            end
        end
    end

endmodule : rob_retire_queue
`default_nettype wire
